// File: rtl/uu_acmac_crc_arb_pkg.sv
// Shared types and constants for the two-requester CRC arbiter.
// Holds the frame state encoding, bus widths and the round-robin pick.
package uu_acmac_crc_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int CRC_W   = 32;
  localparam int LEN_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT,
    ST_DONE,
    ST_CLEAR
  } state_t;

  // Under contention the requester not served last wins; otherwise the lone requester.
  function automatic logic rr_grant(input logic [NUM_REQ-1:0] req, input logic last);
    if (req[0] && req[1]) return ~last;
    return req[1] && !req[0];
  endfunction
endpackage

// File: rtl/uu_acmac_crc_arb_if.sv
// Requester byte streams, completion signals and the CRC engine hookup.
// slave = arbiter side, master = requesters plus engine.
interface uu_acmac_crc_arb_if;
  import uu_acmac_crc_arb_pkg::*;

  logic              req_0, req_1;
  logic [LEN_W-1:0]  len_0, len_1;
  logic              bval_0, bval_1;
  logic [7:0]        bdat_0, bdat_1;
  logic              brdy_0, brdy_1;
  logic              done_0, done_1;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_err;
  logic              eng_en;
  logic              eng_val;
  logic [7:0]        eng_dat;
  logic [LEN_W-1:0]  eng_len;
  logic              eng_avl;
  logic [CRC_W-1:0]  eng_crc;

  modport slave (
    input  req_0, req_1, len_0, len_1, bval_0, bval_1, bdat_0, bdat_1,
    input  eng_avl, eng_crc,
    output brdy_0, brdy_1, done_0, done_1, crc_out, crc_err,
    output eng_en, eng_val, eng_dat, eng_len
  );

  modport master (
    output req_0, req_1, len_0, len_1, bval_0, bval_1, bdat_0, bdat_1,
    output eng_avl, eng_crc,
    input  brdy_0, brdy_1, done_0, done_1, crc_out, crc_err,
    input  eng_en, eng_val, eng_dat, eng_len
  );
endinterface

// File: rtl/uu_acmac_crc_arb.sv
// Round-robin arbiter sharing one CRC engine between a TX and an RX requester.
// Bytes pass straight through to the engine; the result returns as a done pulse.
module uu_acmac_crc_arb
  import uu_acmac_crc_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst_n,
  uu_acmac_crc_arb_if.slave  bus
);
  localparam int WCW = $clog2(TIMEOUT + 1);

  logic [NUM_REQ-1:0]            req, bval, brdy, done;
  logic [NUM_REQ-1:0][LEN_W-1:0] len;
  logic [NUM_REQ-1:0][7:0]       bdat;

  state_t           state, state_nxt;
  logic             gnt, gnt_sel, last;
  logic [LEN_W-1:0] len_q, byte_cnt;
  logic [WCW-1:0]   wait_cnt;
  logic [CRC_W-1:0] crc_q;
  logic             crc_err_q;
  logic             req_gnt, bval_gnt, last_byte, timed_out;
  logic             eng_en, eng_val;
  logic [7:0]       eng_dat;

  assign req  = {bus.req_1, bus.req_0};
  assign len  = {bus.len_1, bus.len_0};
  assign bval = {bus.bval_1, bus.bval_0};
  assign bdat = {bus.bdat_1, bus.bdat_0};

  assign gnt_sel   = rr_grant(req, last);
  assign req_gnt   = req[gnt];
  assign bval_gnt  = bval[gnt];
  assign last_byte = (byte_cnt + LEN_W'(1)) == len_q;
  assign timed_out = wait_cnt == WCW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst_n) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Dropping the granted request outranks every other exit from FEED/WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req) state_nxt = (len[gnt_sel] == '0) ? ST_DONE : ST_FEED;
      ST_FEED: begin
        if (!req_gnt)                   state_nxt = ST_DONE;
        else if (bval_gnt && last_byte) state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (!req_gnt || bus.eng_avl || timed_out) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      gnt       <= 1'b0;
      last      <= 1'b1;
      len_q     <= '0;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      crc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (|req) begin
          gnt      <= gnt_sel;
          len_q    <= len[gnt_sel];
          byte_cnt <= '0;
          wait_cnt <= '0;
          if (len[gnt_sel] == '0) crc_err_q <= 1'b1;
        end
        ST_FEED: begin
          if (!req_gnt)      crc_err_q <= 1'b1;
          else if (bval_gnt) byte_cnt  <= byte_cnt + LEN_W'(1);
        end
        ST_WAIT: begin
          if (!req_gnt) crc_err_q <= 1'b1;
          else if (bus.eng_avl) begin
            crc_q     <= bus.eng_crc;
            crc_err_q <= 1'b0;
          end
          else if (timed_out) crc_err_q <= 1'b1;
          else                wait_cnt  <= wait_cnt + WCW'(1);
        end
        ST_DONE: last <= gnt;
        default: ;
      endcase
    end
  end

  always_comb begin
    brdy    = '0;
    done    = '0;
    eng_en  = 1'b0;
    eng_val = 1'b0;
    eng_dat = '0;
    case (state)
      ST_FEED: begin
        brdy[gnt] = 1'b1;
        eng_en    = 1'b1;
        eng_val   = bval_gnt;
        eng_dat   = bdat[gnt];
      end
      ST_WAIT: eng_en = 1'b1;
      ST_DONE: done[gnt] = 1'b1;
      default: ;
    endcase
  end

  assign bus.brdy_0  = brdy[0];
  assign bus.brdy_1  = brdy[1];
  assign bus.done_0  = done[0];
  assign bus.done_1  = done[1];
  assign bus.crc_out = crc_q;
  assign bus.crc_err = crc_err_q;
  assign bus.eng_en  = eng_en;
  assign bus.eng_val = eng_val;
  assign bus.eng_dat = eng_dat;
  assign bus.eng_len = len_q;
endmodule

// File: tb/tb_uu_acmac_crc_arb.sv
// Bench for uu_acmac_crc_arb: directed frame table, random arbitration traffic
// against an event-level requester/engine model, and reset corner sequences.
module tb_uu_acmac_crc_arb;
  import uu_acmac_crc_arb_pkg::*;

  typedef struct {
    int          who;
    int          len;
    int          drop_after;  // bytes sent before req falls, -1 = never
    int          avl_delay;   // WAIT cycles before eng_avl, -1 = never
    bit          gaps;
    bit          oth;         // other requester holds its request
    int          exp_edge;    // edges from request to done, -1 = unchecked
    int          exp_err;     // -1 = take from model
    bit          chk_crc;
    logic [31:0] exp_crc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          checks = 0;
  int          failures = 0;
  bit          last = 1'b1;
  logic [31:0] held_crc = '0;
  bit          pend [2];
  int          plen [2];

  uu_acmac_crc_arb_if bus();
  uu_acmac_crc_arb #(.TIMEOUT(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic drv(input int r, input bit rq, input logic [15:0] ln, input bit bv, input logic [7:0] bd);
    if (r == 0) begin
      bus.req_0 = rq; bus.len_0 = ln; bus.bval_0 = bv; bus.bdat_0 = bd;
    end else begin
      bus.req_1 = rq; bus.len_1 = ln; bus.bval_1 = bv; bus.bdat_1 = bd;
    end
  endtask

  function automatic logic brdy_of(input int r);
    return (r == 0) ? bus.brdy_0 : bus.brdy_1;
  endfunction

  function automatic logic done_of(input int r);
    return (r == 0) ? bus.done_0 : bus.done_1;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, 32'({bus.brdy_1, bus.brdy_0, bus.done_1, bus.done_0,
                              bus.crc_err, bus.eng_en, bus.eng_val}), 32'h0);
    chk({tag, "_crc_out"}, bus.crc_out, 32'h0);
    chk({tag, "_eng_dat"}, 32'(bus.eng_dat), 32'h0);
    chk({tag, "_eng_len"}, 32'(bus.eng_len), 32'h0);
  endtask

  // Called at a falling edge while the arbiter is idle; returns at the falling
  // edge of the flush cycle that follows the done pulse.
  task automatic run_frame(input vec_t v);
    int          o = 1 - v.who;
    int          sent = 0, wcyc = 0, edge_n = 0;
    bit          started = 0, feeding = 0, waiting = 0, fin = 0, err = 0;
    bit          rq = 1, bv = 0, avl = 0;
    logic [31:0] crc = 32'hFFFF_FFFF;
    logic [7:0]  bd = '0;
    drv(v.who, 1'b1, 16'(v.len), 1'b0, 8'h0);
    drv(o, v.oth, 16'(plen[o]), 1'($urandom_range(0, 1)), 8'($urandom));
    bus.eng_avl = 1'b0;
    while (!fin) begin
      @(posedge clk);
      edge_n++;
      if (!started) begin
        started = 1; feeding = (v.len != 0); fin = (v.len == 0); err = fin;
      end else if (feeding) begin
        if (!rq) begin
          feeding = 0; fin = 1; err = 1;
        end else if (bv) begin
          sent++;
          crc = crc32_upd(crc, bd);
          if (sent == v.len) begin feeding = 0; waiting = 1; end
        end
      end else if (waiting) begin
        wcyc++;
        if (avl) begin waiting = 0; fin = 1; err = 0; end
        else if (wcyc == 64) begin waiting = 0; fin = 1; err = 1; end
      end
      @(negedge clk);
      chk("brdy_gnt", 32'(brdy_of(v.who)), 32'(feeding));
      chk("brdy_oth", 32'(brdy_of(o)), 32'h0);
      chk("eng_en", 32'(bus.eng_en), 32'(feeding || waiting));
      if (feeding || waiting) chk("eng_len", 32'(bus.eng_len), 32'(v.len));
      chk("done_oth", 32'(done_of(o)), 32'h0);
      chk("done_gnt", 32'(done_of(v.who)), 32'(fin));
      if (fin) begin
        if (v.exp_edge >= 0) chk("done_edge", 32'(edge_n), 32'(v.exp_edge));
        chk("crc_err", 32'(bus.crc_err), (v.exp_err >= 0) ? 32'(v.exp_err) : 32'(err));
        if (v.chk_crc)      chk("crc_tbl", bus.crc_out, v.exp_crc);
        else if (!err)      chk("crc_out", bus.crc_out, ~crc);
        else if (v.len == 0) chk("crc_hold", bus.crc_out, held_crc);
        if (!err) held_crc = ~crc;
      end
      if (!fin && edge_n >= 300) begin
        checks++; failures++;
        $display("FAIL frame_budget: no done after %0d cycles, expected done", edge_n);
        fin = 1;
      end
      rq  = rq && !fin && !(feeding && v.drop_after >= 0 && sent == v.drop_after);
      bv  = feeding && rq && (!v.gaps || $urandom_range(0, 3) != 0);
      bd  = v.gaps ? 8'($urandom) : 8'(8'h31 + sent);
      avl = waiting && v.avl_delay >= 0 && wcyc == v.avl_delay;
      bus.eng_avl = avl;
      bus.eng_crc = avl ? ~crc : $urandom;
      drv(v.who, rq, 16'(v.len), bv, bd);
      drv(o, v.oth, 16'(plen[o]), 1'($urandom_range(0, 1)), 8'($urandom));
      #1;
      chk("eng_val", 32'(bus.eng_val), 32'(bv && feeding));
      if (bv && feeding) chk("eng_dat", 32'(bus.eng_dat), 32'(bd));
    end
    bus.eng_avl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("clr_eng_en", 32'(bus.eng_en), 32'h0);
    chk("clr_brdy_done", 32'({bus.brdy_1, bus.brdy_0, bus.done_1, bus.done_0}), 32'h0);
    chk("crc_held", bus.crc_out, held_crc);
    last = v.who[0];
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    int   w;
    // who len drop avl gaps oth edge err chk_crc crc
    tbl[0] = '{0,  9, -1,  0, 0, 0, 11, 0, 1, 32'hCBF4_3926}; // "123456789"
    tbl[1] = '{1,  0, -1,  0, 0, 0,  1, 1, 0, 32'h0};         // bypass, done right after grant
    tbl[2] = '{0, 16,  5,  0, 0, 0,  7, 1, 0, 32'h0};         // abort after 5 bytes
    tbl[3] = '{1,  4, -1,  3, 0, 0,  9, 0, 0, 32'h0};
    tbl[4] = '{0,  2, -1, -1, 0, 0, 67, 1, 0, 32'h0};         // 64 WAIT cycles then timeout
    tbl[5] = '{1,  1, -1,  0, 0, 0,  3, 0, 0, 32'h0};
    tbl[6] = '{0,  3, -1, 63, 0, 0, 68, 0, 0, 32'h0};         // result on final WAIT cycle

    bus.eng_avl = 1'b0;
    bus.eng_crc = '0;
    drv(0, 1'b0, 16'h0, 1'b1, 8'h11);
    drv(1, 1'b0, 16'h0, 1'b1, 8'h22);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");

    // Both requesting as reset releases: 0 first, 1 straight after the flush.
    plen[0] = 4; plen[1] = 4;
    rst_n = 1'b0;
    drv(1, 1'b1, 16'd4, 1'b0, 8'h0);
    run_frame('{0, 4, -1, 0, 0, 1, 6, 0, 0, 32'h0});
    @(negedge clk);
    run_frame('{1, 4, -1, 0, 0, 0, 6, 0, 0, 32'h0});
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i]);
      @(negedge clk);
    end

    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1; plen[r] = $urandom_range(0, 12);
        end
      if (!pend[0] && !pend[1]) begin pend[0] = 1; plen[0] = $urandom_range(0, 12); end
      w = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[0] ? 0 : 1);
      v = '{w, plen[w],
            ($urandom_range(0, 7) == 0 && plen[w] > 0) ? $urandom_range(0, plen[w] - 1) : -1,
            ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 4),
            1, pend[1 - w], -1, -1, 0, 32'h0};
      run_frame(v);
      pend[w] = 0;
      @(negedge clk);
    end
    drv(0, 1'b0, 16'h0, 1'b0, 8'h0);
    drv(1, 1'b0, 16'h0, 1'b0, 8'h0);
    repeat (3) @(negedge clk);

    // Reset while waiting on the engine: frame vanishes without a done pulse.
    drv(0, 1'b1, 16'd2, 1'b0, 8'h0);
    @(negedge clk);
    drv(0, 1'b1, 16'd2, 1'b1, 8'hAA);
    @(negedge clk);
    drv(0, 1'b1, 16'd2, 1'b1, 8'h55);
    @(negedge clk);
    drv(0, 1'b1, 16'd2, 1'b0, 8'h0);
    chk("wait_eng_en", 32'(bus.eng_en), 32'h1);
    chk("wait_brdy", 32'(bus.brdy_0), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rst_wait");
    rst_n = 1'b0;
    drv(0, 1'b0, 16'h0, 1'b0, 8'h0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({bus.done_1, bus.done_0, bus.eng_en}), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
